// File: rtl/noc_credit_pkg.sv
// Shared types and helpers for the credit-based NoC flit transmitter.
package noc_credit_pkg;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BODY = 1'b1
    } tx_state_t;

    // Counter must be able to hold the value 'depth' itself, not just depth-1.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/noc_credit_tx_if.sv
// Link interfaces around the transmitter: valid/ready flit source side and
// send/credit router side.
interface noc_flit_in_if #(
    parameter int FLIT_WIDTH = 64,
    parameter int DEST_WIDTH = 6
);
    logic                  valid;
    logic                  ready;
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  is_tail;

    modport master (output valid, data, dest, is_tail, input ready);
    modport slave  (input valid, data, dest, is_tail, output ready);
endinterface

interface noc_router_if #(
    parameter int FLIT_WIDTH = 64,
    parameter int DEST_WIDTH = 6
);
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  is_tail;
    logic                  send;
    logic                  credit;

    modport master (output data, dest, is_tail, send, input credit);
    modport slave  (input data, dest, is_tail, send, output credit);
endinterface

// File: rtl/noc_credit_counter.sv
// Saturating credit counter: loads DEPTH on reset, sticky flag when a credit
// arrives with the counter already full.
module noc_credit_counter
    import noc_credit_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = credit_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] FULL = WIDTH'(DEPTH);

    logic [WIDTH-1:0] cnt_d, cnt_q;
    logic             ovf_d, ovf_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unique case ({inc, dec})
            2'b10: begin
                if (cnt_q == FULL) ovf_d = 1'b1;
                else               cnt_d = cnt_q + WIDTH'(1);
            end
            2'b01: begin
                if (cnt_q != '0) cnt_d = cnt_q - WIDTH'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all state so every flop
            // samples pre-edge values regardless of statement order.
            cnt_q <= FULL;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign count = cnt_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/noc_credit_tx.sv
// Credit-based flit transmitter into one router input port. Optional
// statistics counters are enabled by defining NOC_CREDIT_TX_STATS_EN.
module noc_credit_tx
    import noc_credit_pkg::*;
#(
    parameter int FLIT_WIDTH        = 64,
    parameter int DEST_WIDTH        = 6,
    parameter int FLIT_BUFFER_DEPTH = 8,
    parameter int CREDIT_WIDTH      = credit_width(FLIT_BUFFER_DEPTH)
) (
    input  logic                    clk_noc,
    input  logic                    rst_n,
    noc_flit_in_if.slave            src,
    noc_router_if.master            rtr,
    output logic [CREDIT_WIDTH-1:0] credits_avail,
    output logic                    pkt_active,
    output logic                    err_credit_ovf
`ifdef NOC_CREDIT_TX_STATS_EN
    ,
    output logic [31:0]             flit_count,
    output logic [31:0]             pkt_count,
    output logic [31:0]             stall_cycles
`endif
);

    tx_state_t             state_d, state_q;
    logic                  send_d, send_q;
    logic                  tail_d, tail_q;
    logic [FLIT_WIDTH-1:0] data_d, data_q;
    logic [DEST_WIDTH-1:0] dest_d, dest_q;
    logic                  accept;

    // Ready comes only from the registered credit count; a credit returned
    // this cycle cannot unblock a flit until the next one.
    assign src.ready = (credits_avail != '0);
    assign accept    = src.valid & src.ready;

    noc_credit_counter #(
        .DEPTH (FLIT_BUFFER_DEPTH),
        .WIDTH (CREDIT_WIDTH)
    ) u_credit (
        .clk   (clk_noc),
        .rst_n (rst_n),
        .inc   (rtr.credit),
        .dec   (accept),
        .count (credits_avail),
        .ovf   (err_credit_ovf)
    );

    // dest_q doubles as the head-destination latch: body flits leave it alone.
    always_comb begin
        state_d = state_q;
        send_d  = 1'b0;
        tail_d  = tail_q;
        data_d  = data_q;
        dest_d  = dest_q;
        if (accept) begin
            send_d = 1'b1;
            data_d = src.data;
            tail_d = src.is_tail;
            unique case (state_q)
                TX_IDLE: begin
                    dest_d = src.dest;
                    if (!src.is_tail) state_d = TX_BODY;
                end
                TX_BODY: begin
                    if (src.is_tail) state_d = TX_IDLE;
                end
                default: state_d = TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            send_q  <= 1'b0;
            tail_q  <= 1'b0;
            data_q  <= '0;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            send_q  <= send_d;
            tail_q  <= tail_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
        end
    end

    assign rtr.data    = data_q;
    assign rtr.dest    = dest_q;
    assign rtr.is_tail = tail_q;
    assign rtr.send    = send_q;
    assign pkt_active  = (state_q == TX_BODY);

`ifdef NOC_CREDIT_TX_STATS_EN
    logic [31:0] flit_cnt_d, flit_cnt_q;
    logic [31:0] pkt_cnt_d,  pkt_cnt_q;
    logic [31:0] stall_d,    stall_q;

    // Free-running counters; wrap modulo 2^32 by construction.
    always_comb begin
        flit_cnt_d = flit_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        stall_d    = stall_q;
        if (accept)                 flit_cnt_d = flit_cnt_q + 32'd1;
        if (accept && src.is_tail)  pkt_cnt_d  = pkt_cnt_q + 32'd1;
        if (src.valid && !src.ready) stall_d   = stall_q + 32'd1;
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            flit_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            stall_q    <= '0;
        end else begin
            flit_cnt_q <= flit_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            stall_q    <= stall_d;
        end
    end

    assign flit_count   = flit_cnt_q;
    assign pkt_count    = pkt_cnt_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_noc_credit_tx.sv
// Directed self-checking bench for noc_credit_tx (depth 8); the stats checks
// are active when NOC_CREDIT_TX_STATS_EN is defined.
module tb_noc_credit_tx;

    logic       clk_noc = 1'b0;
    logic       rst_n   = 1'b0;
    logic [3:0] credits_avail;
    logic       pkt_active;
    logic       err_credit_ovf;
`ifdef NOC_CREDIT_TX_STATS_EN
    logic [31:0] flit_count, pkt_count, stall_cycles;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    noc_flit_in_if #(.FLIT_WIDTH(64), .DEST_WIDTH(6)) src_if ();
    noc_router_if  #(.FLIT_WIDTH(64), .DEST_WIDTH(6)) rtr_if ();

    noc_credit_tx #(
        .FLIT_WIDTH        (64),
        .DEST_WIDTH        (6),
        .FLIT_BUFFER_DEPTH (8)
    ) dut (
        .clk_noc        (clk_noc),
        .rst_n          (rst_n),
        .src            (src_if),
        .rtr            (rtr_if),
        .credits_avail  (credits_avail),
        .pkt_active     (pkt_active),
        .err_credit_ovf (err_credit_ovf)
`ifdef NOC_CREDIT_TX_STATS_EN
        ,
        .flit_count     (flit_count),
        .pkt_count      (pkt_count),
        .stall_cycles   (stall_cycles)
`endif
    );

    always #5 clk_noc = ~clk_noc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_noc);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        src_if.valid   = 1'b0;
        src_if.data    = '0;
        src_if.dest    = '0;
        src_if.is_tail = 1'b0;
        rtr_if.credit  = 1'b0;
        repeat (3) @(posedge clk_noc);
        #1 rst_n = 1'b1;
        #1;

        // Reset state
        chk("rst_in_ready", 64'(src_if.ready), 64'd1);
        chk("rst_credits",  64'(credits_avail), 64'd8);
        chk("rst_send",     64'(rtr_if.send), 64'd0);
        chk("rst_ovf",      64'(err_credit_ovf), 64'd0);
        chk("rst_pkt",      64'(pkt_active), 64'd0);
        chk("rst_data",     rtr_if.data, 64'd0);
        chk("rst_dest",     64'(rtr_if.dest), 64'd0);
        chk("rst_tail",     64'(rtr_if.is_tail), 64'd0);
`ifdef NOC_CREDIT_TX_STATS_EN
        chk("rst_flits", 64'(flit_count), 64'd0);
        chk("rst_pkts",  64'(pkt_count), 64'd0);
        chk("rst_stall", 64'(stall_cycles), 64'd0);
`endif

        // 10 back-to-back single-flit packets without credit return
        for (int i = 0; i < 10; i++) begin
            src_if.valid   = 1'b1;
            src_if.data    = 64'h100 + 64'(i);
            src_if.dest    = 6'h03;
            src_if.is_tail = 1'b1;
            tick();
            chk("b2b_send",    64'(rtr_if.send), (i < 8) ? 64'd1 : 64'd0);
            chk("b2b_credits", 64'(credits_avail), (i < 8) ? 64'(7 - i) : 64'd0);
            if (i < 8) chk("b2b_data", rtr_if.data, 64'h100 + 64'(i));
        end
        chk("b2b_not_ready", 64'(src_if.ready), 64'd0);
        chk("b2b_data_hold", rtr_if.data, 64'h107);

        // One credit: no bypass this cycle, 9th flit goes the next
        src_if.data   = 64'h200;
        rtr_if.credit = 1'b1;
        tick();
        chk("cr1_send",    64'(rtr_if.send), 64'd0);
        chk("cr1_credits", 64'(credits_avail), 64'd1);
        chk("cr1_ready",   64'(src_if.ready), 64'd1);
        rtr_if.credit = 1'b0;
        tick();
        chk("f9_send",    64'(rtr_if.send), 64'd1);
        chk("f9_data",    rtr_if.data, 64'h200);
        chk("f9_credits", 64'(credits_avail), 64'd0);
        src_if.valid = 1'b0;

        // Simultaneous accept and credit at cnt=3
        rtr_if.credit = 1'b1;
        repeat (3) tick();
        chk("sim_pre", 64'(credits_avail), 64'd3);
        src_if.valid = 1'b1;
        src_if.data  = 64'h300;
        tick();
        chk("sim_credits", 64'(credits_avail), 64'd3);
        chk("sim_send",    64'(rtr_if.send), 64'd1);
        src_if.valid = 1'b0;
        repeat (5) tick();
        rtr_if.credit = 1'b0;
        chk("refill", 64'(credits_avail), 64'd8);

        // 4-flit packet: head dest must persist over body dest
        for (int j = 0; j < 4; j++) begin
            src_if.valid   = 1'b1;
            src_if.data    = 64'h400 + 64'(j);
            src_if.dest    = (j == 0) ? 6'h2A : 6'h11;
            src_if.is_tail = (j == 3);
            tick();
            chk("pkt_send",    64'(rtr_if.send), 64'd1);
            chk("pkt_dest",    64'(rtr_if.dest), 64'h2A);
            chk("pkt_tail",    64'(rtr_if.is_tail), (j == 3) ? 64'd1 : 64'd0);
            chk("pkt_active",  64'(pkt_active), (j == 3) ? 64'd0 : 64'd1);
            chk("pkt_credits", 64'(credits_avail), 64'(7 - j));
        end
        src_if.valid = 1'b0;
        tick();
        chk("idle_send", 64'(rtr_if.send), 64'd0);
        chk("idle_dest", 64'(rtr_if.dest), 64'h2A);
        chk("idle_data", rtr_if.data, 64'h403);
        chk("idle_tail", 64'(rtr_if.is_tail), 64'd1);

        // Single-flit packet stays IDLE and takes its own dest
        src_if.valid   = 1'b1;
        src_if.data    = 64'h500;
        src_if.dest    = 6'h05;
        src_if.is_tail = 1'b1;
        tick();
        src_if.valid = 1'b0;
        chk("single_dest", 64'(rtr_if.dest), 64'h05);
        chk("single_pkt",  64'(pkt_active), 64'd0);
        chk("single_tail", 64'(rtr_if.is_tail), 64'd1);
        chk("single_cr",   64'(credits_avail), 64'd3);

        // Credit overflow at full count, sticky
        rtr_if.credit = 1'b1;
        repeat (5) tick();
        chk("ovf_pre_cr",  64'(credits_avail), 64'd8);
        chk("ovf_pre_err", 64'(err_credit_ovf), 64'd0);
        tick();
        chk("ovf_cr",  64'(credits_avail), 64'd8);
        chk("ovf_err", 64'(err_credit_ovf), 64'd1);
        rtr_if.credit = 1'b0;
        repeat (3) tick();
        chk("ovf_sticky", 64'(err_credit_ovf), 64'd1);

        // Head flit, then reset mid-packet
        src_if.valid   = 1'b1;
        src_if.data    = 64'h600;
        src_if.dest    = 6'h07;
        src_if.is_tail = 1'b0;
        tick();
        src_if.valid = 1'b0;
        chk("mid_pkt",     64'(pkt_active), 64'd1);
        chk("mid_credits", 64'(credits_avail), 64'd7);
        chk("mid_ovf",     64'(err_credit_ovf), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pkt",     64'(pkt_active), 64'd0);
        chk("arst_credits", 64'(credits_avail), 64'd8);
        chk("arst_ovf",     64'(err_credit_ovf), 64'd0);
        chk("arst_send",    64'(rtr_if.send), 64'd0);
        chk("arst_data",    rtr_if.data, 64'd0);
        @(posedge clk_noc);
        #1 rst_n = 1'b1;

        // 4 two-flit packets drain credits, then 2 blocked cycles
        for (int p = 0; p < 4; p++) begin
            for (int f = 0; f < 2; f++) begin
                src_if.valid   = 1'b1;
                src_if.data    = 64'h700 + 64'(2 * p + f);
                src_if.dest    = (f == 0) ? 6'(p + 1) : 6'h3F;
                src_if.is_tail = (f == 1);
                tick();
                chk("st_send",    64'(rtr_if.send), 64'd1);
                chk("st_dest",    64'(rtr_if.dest), 64'(p + 1));
                chk("st_credits", 64'(credits_avail), 64'(7 - (2 * p + f)));
            end
        end
        tick();
        chk("blk1_send",  64'(rtr_if.send), 64'd0);
        chk("blk1_ready", 64'(src_if.ready), 64'd0);
        tick();
        chk("blk2_send",  64'(rtr_if.send), 64'd0);
        chk("blk2_cr",    64'(credits_avail), 64'd0);
        src_if.valid = 1'b0;
        tick();
`ifdef NOC_CREDIT_TX_STATS_EN
        chk("stat_flits", 64'(flit_count), 64'd8);
        chk("stat_pkts",  64'(pkt_count), 64'd4);
        chk("stat_stall", 64'(stall_cycles), 64'd2);
`endif
        chk("end_pkt", 64'(pkt_active), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
